// File: rtl/mem_portb_arbiter.sv
// mem_portb_arbiter
//
// Shares data-memory port B between the pipeline MEM stage and a sequential
// byte loader (e.g. a UART boot loader). The CPU wins port B by default; a
// waiting loader that has lost STARVE_LIM arbitrations in a row is granted
// regardless, and the CPU is stalled for that cycle. Exactly one agent drives
// port B in any cycle.
//
// Ports
//   clk, rst          system clock, synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU access request (held while cpu_stall is high)
//   cpu_rdata         combinational read data from port B
//   cpu_stall         CPU request not granted this cycle
//   ld_start          one-cycle pulse, samples ld_base / ld_len
//   ld_base, ld_len   first address and byte count (ld_len = 0 means 2^AW)
//   ld_valid, ld_data loader byte stream
//   ld_ready          loader byte accepted this cycle
//   ld_busy           load in progress
//   ld_done           one-cycle pulse after the final byte is written
//   mem_*_b           memory port B (combinational read)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no load; waiting for ld_start
// LOAD  | loader bytes written to base+cnt as arbitration allows
// DONE  | final byte written; ld_done high for this single cycle

module mem_portb_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic [AW-1:0] mem_addr_b,
    output logic          mem_we_b,
    output logic [DW-1:0] mem_wdata_b,
    input  logic [DW-1:0] mem_rdata_b
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] base, base_nx;
    logic [AW-1:0] len, len_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic          ld_done_nx;
    logic          ld_want, ld_grant, cpu_grant;
    logic          last_byte;
    logic          we_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            len        <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            ld_done    <= 1'b0;
        end else begin
            state      <= state_nx;
            base       <= base_nx;
            len        <= len_nx;
            cnt        <= cnt_nx;
            starve_cnt <= starve_nx;
            ld_done    <= ld_done_nx;
        end
    end

    // Arbitration and port B mux. When nobody is granted the CPU address is
    // still presented so a stalled read sees stable data on the next retry.
    always_comb begin
        ld_want     = (state == LOAD) && ld_valid;
        ld_grant    = ld_want && (!cpu_req || (starve_cnt == SW'(STARVE_LIM)));
        cpu_grant   = cpu_req && !ld_grant;
        mem_addr_b  = cpu_addr;
        mem_wdata_b = cpu_wdata;
        we_sel      = 1'b0;
        if (ld_grant) begin
            mem_addr_b  = base + cnt;
            mem_wdata_b = ld_data;
            we_sel      = 1'b1;
        end else if (cpu_grant) begin
            we_sel      = cpu_we;
        end
    end

    always_comb begin
        state_nx   = state;
        base_nx    = base;
        len_nx     = len;
        cnt_nx     = cnt;
        starve_nx  = starve_cnt;
        ld_done_nx = 1'b0;
        // len = 0 encodes 2^AW: cnt+1 wraps to zero on the last byte.
        last_byte  = ((cnt + AW'(1)) == len);
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nx  = LOAD;
                    base_nx   = ld_base;
                    len_nx    = ld_len;
                    cnt_nx    = '0;
                    starve_nx = '0;
                end
            end
            LOAD: begin
                if (ld_grant) begin
                    cnt_nx    = cnt + AW'(1);
                    starve_nx = '0;
                    if (last_byte) begin
                        state_nx   = DONE;
                        ld_done_nx = 1'b1;
                    end
                end else if (ld_want && (starve_cnt < SW'(STARVE_LIM))) begin
                    starve_nx = starve_cnt + SW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Write enable and handshake are gated by reset so nothing is written
    // while the block is being reset, even mid-load.
    assign ld_ready  = ld_grant & rst;
    assign mem_we_b  = we_sel & rst;
    assign cpu_stall = cpu_req & ~cpu_grant;
    assign cpu_rdata = mem_rdata_b;
    assign ld_busy   = (state == LOAD);

endmodule

// File: tb/tb_mem_portb_arbiter.sv
module tb_mem_portb_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ld_start;
    logic [AW-1:0] ld_base, ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready, ld_busy, ld_done;
    logic [AW-1:0] mem_addr_b;
    logic          mem_we_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;

    always #5 clk = ~clk;

    mem_portb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_len     (ld_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .mem_addr_b (mem_addr_b),
        .mem_we_b   (mem_we_b),
        .mem_wdata_b(mem_wdata_b),
        .mem_rdata_b(mem_rdata_b)
    );

    // Memory behind port B and the expected image of it.
    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    always @(posedge clk) begin
        if (mem_we_b === 1'b1) mem[mem_addr_b] <= mem_wdata_b;
    end
    assign mem_rdata_b = mem[mem_addr_b];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    wr_t        wr_q [$];
    chk_t       chk_q[$];
    logic [7:0] load_bytes[$];

    int n_cmp = 0;
    int n_bad = 0;
    int lost = 0;
    bit prev_last = 1'b0;
    int busy_cycles = 0, ready_cycles = 0, stall_cycles = 0, done_cycles = 0;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor / scoreboard. Loader writes are matched against the queue of
    // expected (address, data) pairs; grant order follows the starvation rule
    // tracked as a count of consecutive losses by a waiting loader.
    always @(negedge clk) begin
        bit   want, exp_lg;
        wr_t  e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (rst !== 1'b1) begin
            if (rst === 1'b0) begin
                cmp("rst_forces_ready_low", ld_ready, 0);
                cmp("rst_forces_we_low", mem_we_b, 0);
            end
            lost      = 0;
            prev_last = 1'b0;
        end else begin
            want   = (wr_q.size() > 0) && (ld_valid === 1'b1);
            exp_lg = want && (!cpu_req || lost == LIM);
            if (want || ld_ready !== 1'b0) cmp("ld_ready", ld_ready, exp_lg);
            if (cpu_req) cmp("cpu_stall", cpu_stall, exp_lg);
            if (ld_done !== 1'b0 || prev_last) cmp("ld_done", ld_done, prev_last);
            prev_last = 1'b0;
            if (ld_ready === 1'b1) begin
                if (wr_q.size() == 0) begin
                    cmp("ld_unexpected_accept", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    cmp("ld_addr", mem_addr_b, e.addr);
                    cmp("ld_wdata", mem_wdata_b, e.data);
                    cmp("ld_we", mem_we_b, 1);
                    ref_mem[e.addr] = e.data;
                    prev_last = e.last;
                end
            end else if (cpu_req && cpu_stall === 1'b0) begin
                cmp("cpu_mem_addr", mem_addr_b, cpu_addr);
                cmp("cpu_mem_we", mem_we_b, cpu_we);
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else cmp("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
            end else if (!cpu_req) begin
                cmp("idle_we", mem_we_b, 0);
            end
            if (exp_lg) lost = 0;
            else if (want && lost < LIM) lost++;
            if (wr_q.size() == 0) lost = 0;
            if (ld_busy === 1'b1)   busy_cycles++;
            if (ld_ready === 1'b1)  ready_cycles++;
            if (cpu_stall === 1'b1) stall_cycles++;
            if (ld_done === 1'b1)   done_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic start_load(input logic [7:0] base, input logic [7:0] len);
        int  n;
        wr_t e;
        n        = (len == 8'd0) ? 256 : int'(len);
        ld_base  = base;
        ld_len   = len;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 8'(i);
            e.data = load_bytes[i];
            e.last = (i == n - 1);
            wr_q.push_back(e);
        end
    endtask

    task automatic feed(input int lim, input int pct);
        int idx = 0;
        int budget = 0;
        while (idx < lim && budget < 4000) begin
            ld_valid = ($urandom_range(99) < pct);
            ld_data  = load_bytes[idx];
            @(negedge clk);
            if (ld_ready === 1'b1) idx++;
            budget++;
            tick();
        end
        ld_valid = 1'b0;
        if (idx < lim) expect_eq("ld_feed_timeout", idx, lim);
    endtask

    task automatic cpu_op(input bit we, input logic [7:0] addr, input logic [7:0] data,
                          output logic [7:0] rd);
        int n = 0;
        bit served = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        rd        = '0;
        while (!served && n < 100) begin
            @(negedge clk);
            served = (cpu_stall === 1'b0);
            rd     = cpu_rdata;
            n++;
            tick();
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        if (!served) expect_eq("cpu_timeout", 0, 1);
    endtask

    task automatic cpu_traffic(input int n);
        logic [7:0] rd;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) tick();
            else cpu_op(1'($urandom_range(1)), 8'(8'h80 + $urandom_range(127)),
                        8'($urandom), rd);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int b0, r0, s0, d0;

        rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hEE;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b1; ld_data = 8'h00;

        // Reset state, with a CPU write and loader data pending that must be blocked.
        repeat (3) tick();
        expect_eq("rst_busy", ld_busy, 0);
        expect_eq("rst_done", ld_done, 0);
        expect_eq("rst_ready", ld_ready, 0);
        expect_eq("rst_we", mem_we_b, 0);
        cpu_we = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        cpu_op(1'b0, 8'h10, 8'h00, rd);
        expect_eq("cpu_read_0x10", rd, 8'h00);

        // Wrapping load, CPU idle.
        load_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        b0 = busy_cycles; r0 = ready_cycles; d0 = done_cycles;
        start_load(8'hFE, 8'd4);
        feed(4, 100);
        tick();
        expect_eq("wrap_busy_cycles", busy_cycles - b0, 4);
        expect_eq("wrap_accepts", ready_cycles - r0, 4);
        expect_eq("wrap_done_pulses", done_cycles - d0, 1);
        expect_eq("wrap_mem_fe", mem[8'hFE], 8'hAA);
        expect_eq("wrap_mem_ff", mem[8'hFF], 8'hBB);
        expect_eq("wrap_mem_00", mem[8'h00], 8'hCC);
        expect_eq("wrap_mem_01", mem[8'h01], 8'hDD);

        // Contention: CPU requests every cycle, loader starves then wins every 5th cycle.
        load_bytes.delete();
        for (int i = 0; i < 8; i++) load_bytes.push_back(8'($urandom));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h90;
        b0 = busy_cycles; r0 = ready_cycles; s0 = stall_cycles; d0 = done_cycles;
        start_load(8'h60, 8'd8);
        feed(8, 100);
        cpu_req = 1'b0;
        tick();
        expect_eq("cont_busy_cycles", busy_cycles - b0, 40);
        expect_eq("cont_accepts", ready_cycles - r0, 8);
        expect_eq("cont_stalls", stall_cycles - s0, 8);
        expect_eq("cont_done_pulses", done_cycles - d0, 1);

        // CPU write then read back; a second ld_start during LOAD is ignored.
        cpu_op(1'b1, 8'h20, 8'h5A, rd);
        cpu_op(1'b0, 8'h20, 8'h00, rd);
        expect_eq("cpu_readback_0x20", rd, 8'h5A);
        load_bytes = '{8'h11, 8'h22, 8'h33};
        b0 = busy_cycles; d0 = done_cycles;
        start_load(8'h30, 8'd3);
        ld_base = 8'h70; ld_len = 8'd5; ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_eq("busy_after_restart", ld_busy, 1);
        feed(3, 100);
        tick();
        expect_eq("restart_busy_cycles", busy_cycles - b0, 4);
        expect_eq("restart_done_pulses", done_cycles - d0, 1);
        expect_eq("restart_idle", ld_busy, 0);
        expect_eq("restart_mem_30", mem[8'h30], 8'h11);
        expect_eq("restart_mem_32", mem[8'h32], 8'h33);
        expect_eq("restart_mem_70", mem[8'h70], 8'h00);

        // Full-depth load (len = 0).
        load_bytes.delete();
        for (int i = 0; i < 256; i++) load_bytes.push_back(8'(i));
        b0 = busy_cycles; d0 = done_cycles;
        start_load(8'h00, 8'd0);
        feed(256, 100);
        tick();
        expect_eq("full_busy_cycles", busy_cycles - b0, 256);
        expect_eq("full_done_pulses", done_cycles - d0, 1);
        for (int i = 0; i < 256; i++) expect_eq("full_mem", mem[i], 32'(i));

        // Reset after 2 of 4 bytes, then a fresh one-byte load.
        load_bytes = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        d0 = done_cycles;
        start_load(8'h50, 8'd4);
        feed(2, 100);
        rst = 1'b0;
        wr_q.delete();
        tick();
        rst = 1'b1;
        expect_eq("abort_busy", ld_busy, 0);
        expect_eq("abort_done", ld_done, 0);
        tick();
        expect_eq("abort_done_later", ld_done, 0);
        expect_eq("abort_done_pulses", done_cycles - d0, 0);
        expect_eq("abort_mem_50", mem[8'h50], 8'hE1);
        expect_eq("abort_mem_51", mem[8'h51], 8'hE2);
        expect_eq("abort_mem_52", mem[8'h52], 8'h52);
        load_bytes = '{8'h77};
        d0 = done_cycles;
        start_load(8'h40, 8'd1);
        feed(1, 100);
        tick();
        expect_eq("after_abort_done", done_cycles - d0, 1);
        expect_eq("after_abort_mem_40", mem[8'h40], 8'h77);

        // Randomised loads with concurrent CPU traffic in a disjoint region.
        for (int t = 0; t < 6; t++) begin
            int         len;
            logic [7:0] base;
            len  = $urandom_range(32, 1);
            base = 8'($urandom_range(8'h3F));
            load_bytes.delete();
            for (int i = 0; i < len; i++) load_bytes.push_back(8'($urandom));
            start_load(base, 8'(len));
            fork
                feed(len, $urandom_range(100, 30));
                cpu_traffic($urandom_range(40, 10));
            join
            tick();
            tick();
        end

        for (int i = 0; i < 256; i++) expect_eq("final_mem_image", mem[i], ref_mem[i]);
        expect_eq("final_queue_empty", wr_q.size(), 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_portb_arbiter.md
Name: mem_portb_arbiter

Overview:
- Shares data-memory port B between the pipeline MEM stage (CPU) and a sequential program/data loader (byte stream, e.g. from a UART receiver).
- The loader is configured with a base address and length. It writes bytes into consecutive addresses while the CPU keeps running.
- The CPU has priority, bounded by a starvation limit. When the CPU loses arbitration, the arbiter drives a stall so the pipeline freezes.
- Sits between the pipeline and the memory's port B. Port A (instruction fetch) is untouched.

Parameters:
- AW, 8, address width; memory depth is 2^AW.
- DW, 8, data width.
- STARVE_LIM, 4, maximum consecutive lost arbitrations by a waiting loader before the loader is force-granted; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU requests port B this cycle.
- cpu_we  in  1  CPU request is a write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data; valid in the same cycle when granted.
- cpu_stall  out  1  CPU request not granted this cycle; the pipeline must hold the request.
- ld_start  in  1  one-cycle pulse that starts a load.
- ld_base  in  AW  first address of the load, sampled at ld_start.
- ld_len  in  AW  byte count, sampled at ld_start; 0 means 2^AW.
- ld_valid  in  1  loader byte is available.
- ld_data  in  DW  loader byte.
- ld_ready  out  1  loader byte accepted this cycle.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse after the last byte is written.
- mem_addr_b  out  AW  to memory port B address.
- mem_we_b  out  1  to memory port B write enable.
- mem_wdata_b  out  DW  to memory port B write data.
- mem_rdata_b  in  DW  from memory port B read data (combinational read).

Behaviour:
- Reset (rst low at a clock edge):
  - State returns to IDLE; cnt, starve_cnt, base and len are cleared; ld_done = 0.
  - While rst is low, mem_we_b = 0 and ld_ready = 0 are forced combinationally.
  - Reset mid-load aborts the load: no ld_done is issued, and bytes already written stay in memory.
- State machine, IDLE / LOAD / DONE:
  - IDLE: ld_start=1 latches ld_base and ld_len, clears cnt and starve_cnt, and moves to LOAD. ld_start in LOAD or DONE is ignored.
  - LOAD: moves to DONE on the edge at which the final byte is accepted (cnt+1 == len, or cnt+1 wraps to 0 when len=0).
  - DONE: lasts one cycle with ld_done=1, then returns to IDLE. ld_done is registered.
  - ld_busy = (state == LOAD).
- Arbitration (combinational, each cycle):
  - ld_want = (state == LOAD) & ld_valid.
  - ld_grant = ld_want & (!cpu_req | starve_cnt == STARVE_LIM).
  - cpu_grant = cpu_req & !ld_grant.
  - cpu_stall = cpu_req & !cpu_grant.
  - ld_ready = ld_grant. The loader source must not wait for ld_ready before asserting ld_valid.
- Starvation counter:
  - Increments when ld_want & !ld_grant, saturating at STARVE_LIM.
  - Clears on ld_grant, and holds when ld_want=0.
- Port B mux:
  - ld_grant: mem_addr_b = base + cnt (mod 2^AW, so loads wrap past the top address), mem_we_b = 1, mem_wdata_b = ld_data. cnt increments at the edge.
  - cpu_grant: mem_addr_b = cpu_addr, mem_we_b = cpu_we, mem_wdata_b = cpu_wdata.
  - Neither granted: mem_addr_b = cpu_addr, mem_we_b = 0.
- cpu_rdata = mem_rdata_b, meaningful only when cpu_grant & !cpu_we.
- Exactly one agent accesses port B per cycle, so a same-address CPU/loader conflict cannot occur.
- A CPU write is visible to a CPU read in the next cycle, because the memory writes on the clock edge.

Test Plan:
- Reset → ld_busy=0, ld_done=0, ld_ready=0, mem_we_b=0; cpu_req=1, cpu_we=0, cpu_addr=0x10 → cpu_stall=0, mem_addr_b=0x10.
- Load: ld_base=0xFE, ld_len=4, 4 bytes AA,BB,CC,DD with ld_valid held high and cpu_req=0 → mem[0xFE]=AA, mem[0xFF]=BB, mem[0x00]=CC, mem[0x01]=DD; ld_done high exactly one cycle after the 4th accept; ld_busy high for exactly 4 cycles.
- Contention: STARVE_LIM=4, cpu_req held high, ld_valid held high during an 8-byte load → loader granted on every 5th cycle; cpu_stall=1 only in those cycles; 8 bytes finish in 40 cycles.
- CPU traffic alone: write 0x5A to 0x20, next cycle read 0x20 → cpu_rdata=0x5A, cpu_stall=0 throughout; a second ld_start during LOAD is ignored and base is unchanged.
- ld_len=0, base=0x00, 256 bytes of value i at address i → all 256 locations written, ld_done after the 256th accept.
- Assert rst low after 2 of 4 bytes → next cycle state IDLE, ld_busy=0, no ld_done; a new ld_start with base=0x40, len=1 completes normally.
